rot_match_seq: RTL and testbench
================================

# rot_match_seq

Sequencer that sits upstream of the 4-bit barrel rotator, driving its data and shift-select inputs and consuming its outputs. On a start request it latches a 4-bit word and a 4-bit target, then sweeps the rotator through all four rotate-right amounts, one per clock. It reports which rotations equal the target, the lowest matching amount, and a one-cycle done pulse. The result feeds the alignment/sync logic that needs the rotation that realigns a received nibble.

## Interface
Parameters: none. Width fixed at 4 bits to match the rotator.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only in IDLE
- word  in  4  data word; sampled with an accepted start
- target  in  4  pattern to match; sampled with an accepted start
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; results are valid
- found  out  1  at least one rotation matched
- amount  out  2  lowest matching rotate-right amount; 0 if none matched
- match_mask  out  4  bit k set means the word rotated right by k equals target
- rot_in  out  4  to rotator data inputs; bit i drives in_i
- rot_sel  out  2  to rotator shift select; {shift_by1, shift_by0}
- rot_out  in  4  from rotator outputs; bit i from out_i; combinational path

## Operation
- Rotator contract: rot_out[i] = rot_in[(i + rot_sel) mod 4], which is a rotate right by rot_sel. The path is combinational within the same cycle.
- FSM states: IDLE, SWEEP, DONE.
- IDLE with start=1:
  - latch word into word_q and target into target_q
  - drive rot_in from word_q
  - clear match_mask, found and amount
  - set cnt to 0 and rot_sel to 0
  - go to SWEEP
- SWEEP, each cycle:
  - compare rot_out with target_q
  - at the next edge, set match_mask[cnt] to the compare result
  - if cnt is less than 3: increment cnt and rot_sel, stay in SWEEP
  - if cnt equals 3: go to DONE and register the results
  - found = OR of the final mask
  - amount = index of the lowest set bit of the final mask, or 0 if the mask is empty
- DONE: done=1 for exactly one cycle, then go to IDLE.
- The sweep always covers all four rotations; there is no early exit.
- start is ignored in SWEEP and DONE. It is not queued.
- rot_in, rot_sel and all results hold their values in IDLE until the next accepted start.
- word and target are don't-care except in the cycle a start is accepted.
- Reset, asynchronous, any state:
  - state returns to IDLE, cnt to 0
  - all outputs drive 0: busy, done, found, amount, match_mask, rot_in, rot_sel
  - any in-flight sweep is abandoned with no done pulse

## Timing
- E0 is the edge at which start is accepted.
- rot_sel equals k during the cycle from E(k) to E(k+1), for k = 0 to 3.
- match_mask[k] is registered at edge E(k+1).
- At E4: state becomes DONE, done rises, and found, amount and the full match_mask are valid.
- At E5: done falls and state returns to IDLE. busy is high from E0 to E5.
- The earliest next accepted start is E6, giving one job per 6 cycles.
- A start asserted during the DONE cycle is dropped.
- Latency from start to done is fixed at 4 cycles.

## Structure
- Shared package (rot_pkg):
  - ROT_W = 4
  - SEL_W = 2
  - state enum: IDLE, SWEEP, DONE
  - rotate-right reference function, reused by benches
- No sub-module. The rotator is instantiated beside this block at the next level up, not inside it. Benches wire in a behavioural rotator built from the package function.

## Test plan
- word=0001, target=1000 -> done at E4, match_mask=0010, found=1, amount=1.
- word=1010, target=0101 -> match_mask=1010, found=1, amount=1 (lowest of the two matches).
- word=0000, target=0000 -> match_mask=1111, amount=0; word=0011, target=0111 -> match_mask=0000, found=0, amount=0.
- Accept start (word=0110, target=0011, expect mask=0010, amount=1), then pulse start with word=1111 at E2 and again during DONE -> both ignored; results unchanged; the next start is accepted at E6.
- Assert rst at E2 mid-sweep -> all outputs 0 immediately, no done pulse; deassert rst and start word=0001, target=0010 -> mask=1000, amount=3, done at E4.
- Reset value check at power-up: all outputs 0 and busy=0 before any start.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared definitions for the rotate-and-match sequencer and its benches.
package rot_pkg;

  localparam int ROT_W = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } rot_state_e;

  // Rotate right: out[i] = d[(i + s) mod ROT_W]; mirrors the external rotator.
  function automatic logic [ROT_W-1:0] rot_right(input logic [ROT_W-1:0] d,
                                                 input logic [SEL_W-1:0] s);
    logic [2*ROT_W-1:0] dd;
    dd = {d, d} >> s;
    return dd[ROT_W-1:0];
  endfunction

  // Index of the lowest set bit, 0 when no bit is set.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [ROT_W-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = ROT_W - 1; i >= 0; i--) begin
      if (m[i]) r = i[SEL_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/rot_match_seq_if.sv
// Link between the sequencer and the external 4-bit barrel rotator.
// The rotator is purely combinational: rot_out reflects rot_in/rot_sel within
// the same cycle, so there is no valid/ready pair on this link; the
// sequencer's own job handshake is start (accepted only while busy=0) and a
// one-cycle done pulse that marks the results valid.
interface rot_match_seq_if;
  import rot_pkg::*;

  logic [ROT_W-1:0] rot_in;
  logic [SEL_W-1:0] rot_sel;
  logic [ROT_W-1:0] rot_out;

  // Sequencer side: drives data and shift amount, reads the rotated word.
  modport master (output rot_in, output rot_sel, input rot_out);
  // Rotator side.
  modport slave  (input rot_in, input rot_sel, output rot_out);

endinterface

// File: rtl/rot_match_seq.sv
// Sweeps an external rotator through all four rotate-right amounts and
// reports which rotations of the latched word equal the latched target.
module rot_match_seq
  import rot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROT_W-1:0]  word,
  input  logic [ROT_W-1:0]  target,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [SEL_W-1:0]  amount,
  output logic [ROT_W-1:0]  match_mask,
  rot_match_seq_if.master   rot,
  output rot_state_e        state_dbg
);

  rot_state_e       state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [ROT_W-1:0] word_q, word_d;
  logic [ROT_W-1:0] target_q, target_d;
  logic [ROT_W-1:0] mask_q, mask_d;
  logic             found_q, found_d;
  logic [SEL_W-1:0] amount_q, amount_d;
  logic             hit;

  // State and datapath registers; reset abandons any sweep and zeroes outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      target_q <= '0;
      mask_q   <= '0;
      found_q  <= 1'b0;
      amount_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      target_q <= target_d;
      mask_q   <= mask_d;
      found_q  <= found_d;
      amount_q <= amount_d;
    end
  end

  // Next-state and datapath update: one rotation compared per SWEEP cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    target_d = target_q;
    mask_d   = mask_q;
    found_d  = found_q;
    amount_d = amount_q;
    hit      = (rot.rot_out == target_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          word_d   = word;
          target_d = target;
          mask_d   = '0;
          found_d  = 1'b0;
          amount_d = '0;
          cnt_d    = '0;
          state_d  = SWEEP;
        end
      end
      SWEEP: begin
        mask_d[cnt_q] = hit;
        if (cnt_q == SEL_W'(ROT_W - 1)) begin
          // Last rotation: summarise the completed mask.
          found_d  = |mask_d;
          amount_d = lowest_set(mask_d);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // rot_sel tracks the sweep counter; both hold after the sweep ends.
  assign rot.rot_in  = word_q;
  assign rot.rot_sel = cnt_q;

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign found      = found_q;
  assign amount     = amount_q;
  assign match_mask = mask_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rot_match_seq.sv
// Bench for rot_match_seq: behavioural rotator plus an arithmetic reference
// model of the match search.
module tb_rot_match_seq;
  import rot_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] word;
  logic [3:0] target;
  logic       busy;
  logic       done;
  logic       found;
  logic [1:0] amount;
  logic [3:0] match_mask;
  rot_state_e state_dbg;

  int total;
  int bad;

  // expected {found, amount, match_mask}
  logic [6:0] exp_q[$];

  rot_match_seq_if link ();

  assign link.rot_out = rot_right(link.rot_in, link.rot_sel);

  rot_match_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word       (word),
    .target     (target),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .amount     (amount),
    .match_mask (match_mask),
    .rot        (link.master),
    .state_dbg  (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: try every rotate-right amount with plain shifts
  function automatic logic [6:0] model(input logic [3:0] w, input logic [3:0] t);
    logic [3:0] m;
    logic [1:0] a;
    logic       f;
    int         v;
    m = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      v = ((int'(w) >> k) | (int'(w) << (4 - k))) & 15;
      if (v == int'(t)) m[k] = 1'b1;
    end
    f = (m != 4'b0000);
    a = 2'd0;
    for (int k = 3; k >= 0; k--) if (m[k]) a = 2'(k);
    return {f, a, m};
  endfunction

  // Full job: start accepted at E0, done expected exactly at E4, idle at E5.
  task automatic run_job(input logic [3:0] w, input logic [3:0] t, input string name);
    logic [6:0] exp;
    int lat;
    exp_q.push_back(model(w, t));
    @(negedge clk);
    start = 1'b1; word = w; target = t;
    @(posedge clk); #1;
    start = 1'b0; word = 4'($urandom); target = 4'($urandom);
    total++;
    if ({busy, done, link.rot_in, link.rot_sel, match_mask} !== {1'b1, 1'b0, w, 2'd0, 4'd0}) begin
      bad++;
      $display("FAIL %s_accept: got busy=%b done=%b rot_in=%b sel=%0d mask=%b want 1 0 %b 0 0000",
               name, busy, done, link.rot_in, link.rot_sel, match_mask, w);
    end
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      total++;
      if ({done, link.rot_sel} !== {1'b0, 2'(k)}) begin
        bad++;
        $display("FAIL %s_sweep%0d: got done=%b sel=%0d want 0 %0d", name, k, done, link.rot_sel, k);
      end
    end
    lat = 3;
    while (lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL %s_latency: got %0d want 4", name, lat);
    end
    exp = exp_q.pop_front();
    total++;
    if ({found, amount, match_mask} !== exp) begin
      bad++;
      $display("FAIL %s_result: got found=%b amount=%0d mask=%b want found=%b amount=%0d mask=%b",
               name, found, amount, match_mask, exp[6], exp[5:4], exp[3:0]);
    end
    @(posedge clk); #1;
    total++;
    if ({busy, done, found, amount, match_mask} !== {2'b00, exp}) begin
      bad++;
      $display("FAIL %s_hold: got busy=%b done=%b found=%b amount=%0d mask=%b",
               name, busy, done, found, amount, match_mask);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; word = 4'd0; target = 4'd0;
    #1;
    total++;
    if ({busy, done, found, amount, match_mask, link.rot_in, link.rot_sel} !== 15'd0 ||
        state_dbg !== IDLE) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b found=%b amount=%0d mask=%b rot_in=%b sel=%0d state=%0d want all 0",
               busy, done, found, amount, match_mask, link.rot_in, link.rot_sel, state_dbg);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, done, found} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release: got busy=%b done=%b found=%b want 000", busy, done, found);
    end
  endtask

  task automatic test_directed();
    run_job(4'b0001, 4'b1000, "dir_single");
    run_job(4'b1010, 4'b0101, "dir_two");
    run_job(4'b0000, 4'b0000, "dir_all");
    run_job(4'b0011, 4'b0111, "dir_none");
  endtask

  task automatic test_random();
    logic [3:0] w, t;
    for (int n = 0; n < 24; n++) begin
      w = 4'($urandom);
      if ($urandom_range(0, 1) == 1) t = rot_right(w, 2'($urandom_range(0, 3)));
      else t = 4'($urandom);
      run_job(w, t, "rand");
    end
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    start = 1'b1; word = 4'b0110; target = 4'b0011;
    @(posedge clk); #1;               // E0
    start = 1'b0;
    @(posedge clk); #1;               // E1
    start = 1'b1; word = 4'b1111; target = 4'b1111;
    @(posedge clk); #1;               // E2
    start = 1'b0;
    total++;
    if ({busy, link.rot_in} !== {1'b1, 4'b0110}) begin
      bad++;
      $display("FAIL ign_sweep_start: got busy=%b rot_in=%b want 1 0110", busy, link.rot_in);
    end
    @(posedge clk);                   // E3
    @(posedge clk); #1;               // E4
    total++;
    if ({done, found, amount, match_mask} !== {1'b1, 1'b1, 2'd1, 4'b0010}) begin
      bad++;
      $display("FAIL ign_result: got done=%b found=%b amount=%0d mask=%b want 1 1 1 0010",
               done, found, amount, match_mask);
    end
    start = 1'b1; word = 4'b1111; target = 4'b1111;
    @(posedge clk); #1;               // E5: start during DONE dropped
    total++;
    if ({busy, done, found, amount, match_mask, link.rot_in} !== {1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0110}) begin
      bad++;
      $display("FAIL ign_done_start: got busy=%b done=%b found=%b amount=%0d mask=%b rot_in=%b want 0 0 1 1 0010 0110",
               busy, done, found, amount, match_mask, link.rot_in);
    end
    word = 4'b0001; target = 4'b1000;
    @(posedge clk); #1;               // E6: accepted
    start = 1'b0;
    total++;
    if ({busy, link.rot_in, match_mask} !== {1'b1, 4'b0001, 4'b0000}) begin
      bad++;
      $display("FAIL ign_e6_accept: got busy=%b rot_in=%b mask=%b want 1 0001 0000", busy, link.rot_in, match_mask);
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({done, found, amount, match_mask} !== {1'b1, model(4'b0001, 4'b1000)}) begin
      bad++;
      $display("FAIL ign_e6_result: got done=%b found=%b amount=%0d mask=%b want 1 1 1 0010",
               done, found, amount, match_mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int done_seen;
    @(negedge clk);
    start = 1'b1; word = 4'b1011; target = 4'b1101;
    @(posedge clk); #1;               // E0
    start = 1'b0;
    @(posedge clk);                   // E1
    @(posedge clk); #1;               // E2
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, found, amount, match_mask, link.rot_in, link.rot_sel} !== 15'd0 ||
        state_dbg !== IDLE) begin
      bad++;
      $display("FAIL midrst_outputs: got busy=%b done=%b found=%b amount=%0d mask=%b rot_in=%b sel=%0d want all 0",
               busy, done, found, amount, match_mask, link.rot_in, link.rot_sel);
    end
    done_seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done !== 1'b0) done_seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL midrst_no_done: got %0d cycles with done/busy high want 0", done_seen);
    end
    run_job(4'b0001, 4'b0010, "midrst_next");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_mid_reset();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
